usb2_ep_sched: RTL and testbench
================================

USB2_EP_SCHED -- requirements
Module: usb2_ep_sched

Interface
REQ-001 Parameter EP_MASK, default 4'b1111, endpoints 0..3 implemented (bit n = EP n present).
REQ-002 Parameter TIMEOUT_CYC, default 8'd255, max phy_clk cycles in a data wait state.
REQ-003 phy_clk  in  1  single clock, all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 tok_valid  in  1  one-cycle pulse, decoded token available.
REQ-006 tok_pid  in  4  token PID (OUT=E, IN=6, SOF=A, SETUP=2).
REQ-007 tok_ep  in  4  token endpoint number.
REQ-008 xfer_done  in  1  one-cycle pulse, data phase (OUT/SETUP) or host handshake (IN) finished.
REQ-009 data_pid  in  4  received DATA PID, valid with xfer_done.
REQ-010 data_crc_ok  in  1  received packet CRC good, valid with xfer_done.
REQ-011 host_ack  in  1  host returned ACK to IN data, valid with xfer_done.
REQ-012 ep_ready  in  4  per-EP: OUT buffer free / IN data available.
REQ-013 ep_stall  in  4  per-EP halt.
REQ-014 toggle_clr  in  4  per-EP pulse forcing data toggle to DATA0.
REQ-015 ep_xfer_in  out  4  per-EP level, host-to-device data phase in progress.
REQ-016 ep_xfer_out  out  4  per-EP level, device-to-host data phase in progress.
REQ-017 ep_xfer_pid  out  4  token PID of current transfer.
REQ-018 tx_data_pid  out  4  DATA0 (C) / DATA1 (4) for IN response.
REQ-019 hs_valid  out  1  one-cycle pulse, handshake to send.
REQ-020 hs_pid  out  4  ACK (D) / NAK (5) / STALL (1), valid with hs_valid.
REQ-021 busy  out  1  high in any state other than IDLE.
REQ-022 dup_drop  out  1  one-cycle pulse, OUT data was a duplicate.
REQ-023 err_timeout  out  1  one-cycle pulse, wait state timed out.

Function
REQ-024 States: IDLE, OUT_WAIT, IN_WAIT, HSK; at most one ep_xfer_in/ep_xfer_out bit high at any time.
REQ-025 IDLE, tok_valid: SOF, tok_ep>3, or EP_MASK[tok_ep]=0 -> ignored, stay IDLE, no outputs.
REQ-026 IDLE, tok_valid, OUT/IN, ep_stall set -> hs_valid/STALL next cycle, stay IDLE.
REQ-027 IDLE, tok_valid, OUT/IN, ep_ready clear -> hs_valid/NAK next cycle, stay IDLE.
REQ-028 SETUP to EP0 always accepted (stall/ready ignored); EP0 toggle forced to DATA0; SETUP to EP1..3 ignored.
REQ-029 Accepted OUT/SETUP: next cycle ep_xfer_in[ep]=1, ep_xfer_pid=tok_pid, state OUT_WAIT.
REQ-030 Accepted IN: next cycle ep_xfer_out[ep]=1, tx_data_pid from toggle[ep], state IN_WAIT.
REQ-031 Strobes stay high until cycle after xfer_done or timeout, then drop together with transition.
REQ-032 OUT_WAIT, xfer_done, crc bad -> IDLE, no handshake, toggle unchanged.
REQ-033 OUT_WAIT, xfer_done, crc good, data_pid matches toggle -> HSK (ACK), toggle flips.
REQ-034 OUT_WAIT, xfer_done, crc good, data_pid mismatch -> HSK (ACK), toggle unchanged, dup_drop pulses.
REQ-035 HSK: hs_valid pulses one cycle, then IDLE; handshake latency = 1 cycle after xfer_done.
REQ-036 IN_WAIT, xfer_done: host_ack=1 -> toggle flips; either way -> IDLE, no hs_valid.
REQ-037 8-bit wait counter cleared on entering OUT_WAIT/IN_WAIT; at count = TIMEOUT_CYC without xfer_done -> IDLE, err_timeout pulse, toggle unchanged.
REQ-038 tok_valid outside IDLE ignored; xfer_done in IDLE ignored.
REQ-039 toggle_clr coincident with a toggle flip on same EP: clear wins (result DATA0).
REQ-040 hs_pid holds last value when hs_valid low.

Reset
REQ-041 reset: state IDLE, all toggles DATA0, counter 0, all outputs 0 (tx_data_pid = C) on the following cycle, including mid-transfer.
REQ-042 reset has priority over every other input in the same cycle.

Verification
REQ-043 OUT EP2, ready, DATA0, crc ok -> ep_xfer_in=4'b0100 until done, ACK 1 cycle after xfer_done, toggle[2]=1.
REQ-044 Repeat OUT EP2 with DATA0 -> ACK, dup_drop=1, toggle[2] stays 1.
REQ-045 IN EP1, ep_ready[1]=0 -> hs_pid=5 next cycle, ep_xfer_out stays 0; ep_stall[1]=1 -> hs_pid=1.
REQ-046 IN EP3 ready, no xfer_done for 255 cycles -> err_timeout pulse, ep_xfer_out drops, tx_data_pid unchanged next IN.
REQ-047 SETUP EP0 with ep_stall[0]=1 -> accepted, toggle[0]=0; reset asserted in OUT_WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/usb2_ep_sched_if.sv
// Token/data-phase bus between the USB2 packet decoder and the endpoint scheduler.
// The master side decodes packets; the slave side is the scheduler.
interface usb2_ep_sched_if;
  logic       tok_valid;
  logic [3:0] tok_pid;
  logic [3:0] tok_ep;
  logic       xfer_done;
  logic [3:0] data_pid;
  logic       data_crc_ok;
  logic       host_ack;
  logic [3:0] ep_ready;
  logic [3:0] ep_stall;
  logic [3:0] toggle_clr;
  logic [3:0] ep_xfer_in;
  logic [3:0] ep_xfer_out;
  logic [3:0] ep_xfer_pid;
  logic [3:0] tx_data_pid;
  logic       hs_valid;
  logic [3:0] hs_pid;
  logic       busy;
  logic       dup_drop;
  logic       err_timeout;

  modport master (
    output tok_valid, tok_pid, tok_ep, xfer_done, data_pid, data_crc_ok, host_ack,
           ep_ready, ep_stall, toggle_clr,
    input  ep_xfer_in, ep_xfer_out, ep_xfer_pid, tx_data_pid, hs_valid, hs_pid,
           busy, dup_drop, err_timeout
  );

  modport slave (
    input  tok_valid, tok_pid, tok_ep, xfer_done, data_pid, data_crc_ok, host_ack,
           ep_ready, ep_stall, toggle_clr,
    output ep_xfer_in, ep_xfer_out, ep_xfer_pid, tx_data_pid, hs_valid, hs_pid,
           busy, dup_drop, err_timeout
  );
endinterface

// File: rtl/usb2_ep_sched.sv
// USB2 device endpoint scheduler: token accept/NAK/STALL, data toggle tracking,
// wait-state timeout and handshake generation for up to four endpoints.
module usb2_ep_sched #(
  parameter logic [3:0] EP_MASK     = 4'b1111,
  parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
  input  logic          phy_clk,
  input  logic          reset,
  usb2_ep_sched_if.slave bus
);
  // PID values are the upper (check) nibble of the PID byte
  localparam logic [3:0] PID_OUT   = 4'hE;
  localparam logic [3:0] PID_IN    = 4'h6;
  localparam logic [3:0] PID_SETUP = 4'h2;
  localparam logic [3:0] PID_DATA0 = 4'hC;
  localparam logic [3:0] PID_DATA1 = 4'h4;
  localparam logic [3:0] PID_ACK   = 4'hD;
  localparam logic [3:0] PID_NAK   = 4'h5;
  localparam logic [3:0] PID_STALL = 4'h1;

  typedef enum logic [1:0] {IDLE, OUT_WAIT, IN_WAIT, HSK} state_t;

  state_t     state_reg;
  logic [1:0] ep_reg;
  logic [7:0] wait_cnt_reg;
  logic [3:0] toggle_reg;
  logic [3:0] ep_xfer_in_reg;
  logic [3:0] ep_xfer_out_reg;
  logic [3:0] ep_xfer_pid_reg;
  logic [3:0] tx_data_pid_reg;
  logic       hs_valid_reg;
  logic [3:0] hs_pid_reg;
  logic       busy_reg;
  logic       dup_drop_reg;
  logic       err_timeout_reg;

  logic [1:0] tok_idx;
  logic       tok_ep_ok;
  logic       data_match;
  logic [8:0] wait_cnt_inc;
  logic       wait_expired;
  logic [3:0] toggle_flip;
  logic       setup_clr;

  assign tok_idx      = bus.tok_ep[1:0];
  assign tok_ep_ok    = (bus.tok_ep[3:2] == 2'b00) && EP_MASK[tok_idx];
  assign data_match   = bus.data_pid == (toggle_reg[ep_reg] ? PID_DATA1 : PID_DATA0);
  assign wait_cnt_inc = {1'b0, wait_cnt_reg} + 9'd1;
  // The wait state lasts at most TIMEOUT_CYC cycles; a late xfer_done still wins
  assign wait_expired = wait_cnt_inc == {1'b0, TIMEOUT_CYC};

  always_comb begin
    toggle_flip = 4'b0000;
    setup_clr   = 1'b0;
    if (state_reg == OUT_WAIT && bus.xfer_done && bus.data_crc_ok && data_match)
      toggle_flip[ep_reg] = 1'b1;
    if (state_reg == IN_WAIT && bus.xfer_done && bus.host_ack)
      toggle_flip[ep_reg] = 1'b1;
    if (state_reg == IDLE && bus.tok_valid && tok_ep_ok &&
        bus.tok_pid == PID_SETUP && tok_idx == 2'd0)
      setup_clr = 1'b1;
  end

  // Per-endpoint data toggle; an explicit clear beats a coincident flip
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_toggle
      always_ff @(posedge phy_clk) begin
        if (reset)
          toggle_reg[gi] <= 1'b0;
        else if (bus.toggle_clr[gi] || (setup_clr && gi == 0))
          toggle_reg[gi] <= 1'b0;
        else if (toggle_flip[gi])
          toggle_reg[gi] <= ~toggle_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge phy_clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      ep_reg          <= 2'd0;
      wait_cnt_reg    <= 8'd0;
      ep_xfer_in_reg  <= 4'b0000;
      ep_xfer_out_reg <= 4'b0000;
      ep_xfer_pid_reg <= 4'h0;
      tx_data_pid_reg <= PID_DATA0;
      hs_valid_reg    <= 1'b0;
      hs_pid_reg      <= 4'h0;
      busy_reg        <= 1'b0;
      dup_drop_reg    <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      hs_valid_reg    <= 1'b0;
      dup_drop_reg    <= 1'b0;
      err_timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.tok_valid && tok_ep_ok) begin
            if ((bus.tok_pid == PID_SETUP && tok_idx == 2'd0) ||
                (bus.tok_pid == PID_OUT && !bus.ep_stall[tok_idx] && bus.ep_ready[tok_idx])) begin
              ep_xfer_in_reg  <= 4'b0001 << tok_idx;
              ep_xfer_pid_reg <= bus.tok_pid;
              ep_reg          <= tok_idx;
              wait_cnt_reg    <= 8'd0;
              busy_reg        <= 1'b1;
              state_reg       <= OUT_WAIT;
            end else if (bus.tok_pid == PID_IN && !bus.ep_stall[tok_idx] && bus.ep_ready[tok_idx]) begin
              ep_xfer_out_reg <= 4'b0001 << tok_idx;
              ep_xfer_pid_reg <= bus.tok_pid;
              tx_data_pid_reg <= toggle_reg[tok_idx] ? PID_DATA1 : PID_DATA0;
              ep_reg          <= tok_idx;
              wait_cnt_reg    <= 8'd0;
              busy_reg        <= 1'b1;
              state_reg       <= IN_WAIT;
            end else if (bus.tok_pid == PID_OUT || bus.tok_pid == PID_IN) begin
              hs_valid_reg <= 1'b1;
              hs_pid_reg   <= bus.ep_stall[tok_idx] ? PID_STALL : PID_NAK;
            end
          end
        end
        OUT_WAIT: begin
          if (bus.xfer_done) begin
            ep_xfer_in_reg <= 4'b0000;
            if (bus.data_crc_ok) begin
              // Duplicates are still ACKed so the host advances its toggle
              hs_valid_reg <= 1'b1;
              hs_pid_reg   <= PID_ACK;
              dup_drop_reg <= !data_match;
              state_reg    <= HSK;
            end else begin
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end
          end else if (wait_expired) begin
            ep_xfer_in_reg  <= 4'b0000;
            err_timeout_reg <= 1'b1;
            busy_reg        <= 1'b0;
            state_reg       <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_inc[7:0];
          end
        end
        IN_WAIT: begin
          if (bus.xfer_done || wait_expired) begin
            ep_xfer_out_reg <= 4'b0000;
            err_timeout_reg <= !bus.xfer_done;
            busy_reg        <= 1'b0;
            state_reg       <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_inc[7:0];
          end
        end
        HSK: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ep_xfer_in  = ep_xfer_in_reg;
  assign bus.ep_xfer_out = ep_xfer_out_reg;
  assign bus.ep_xfer_pid = ep_xfer_pid_reg;
  assign bus.tx_data_pid = tx_data_pid_reg;
  assign bus.hs_valid    = hs_valid_reg;
  assign bus.hs_pid      = hs_pid_reg;
  assign bus.busy        = busy_reg;
  assign bus.dup_drop    = dup_drop_reg;
  assign bus.err_timeout = err_timeout_reg;
endmodule

// File: tb/tb_usb2_ep_sched.sv
// Directed bench for usb2_ep_sched: a transaction-level reference model is compared
// against the DUT every cycle, plus hand-computed expectations at key points.
module tb_usb2_ep_sched;
  localparam int TMO = 255;

  logic phy_clk;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  usb2_ep_sched_if bus ();

  usb2_ep_sched #(.EP_MASK(4'b1111), .TIMEOUT_CYC(8'd255)) dut (
    .phy_clk (phy_clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial phy_clk = 1'b0;
  always #5 phy_clk = ~phy_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: endpoint activity described as a mode plus wait-cycle count
  typedef enum int {M_IDLE, M_RX, M_TX, M_ACK} mode_t;
  mode_t      m_mode;
  int         m_ep;
  int         m_wait;
  logic [3:0] m_tog;
  bit         m_live = 0;
  logic [3:0] e_xpid, e_tx, e_hs;
  logic       e_hsv, e_dup, e_tmo;

  function automatic logic [3:0] data_pid_of(input logic t);
    return t ? 4'h4 : 4'hC;
  endfunction

  always @(posedge phy_clk) begin
    logic [3:0] nt;
    int         ep;
    if (reset) begin
      m_mode = M_IDLE; m_ep = 0; m_wait = 0; m_tog = 4'b0000;
      e_xpid = 4'h0; e_tx = 4'hC; e_hs = 4'h0;
      e_hsv = 0; e_dup = 0; e_tmo = 0;
      m_live = 1;
    end else if (m_live) begin
      nt = m_tog;
      e_hsv = 0; e_dup = 0; e_tmo = 0;
      ep = int'(bus.tok_ep);
      case (m_mode)
        M_IDLE: begin
          if (bus.tok_valid && ep < 4) begin
            if (bus.tok_pid == 4'h2 && ep == 0) begin
              nt[0] = 1'b0; m_mode = M_RX; m_ep = 0; m_wait = 0; e_xpid = 4'h2;
            end else if (bus.tok_pid == 4'hE || bus.tok_pid == 4'h6) begin
              if (bus.ep_stall[ep]) begin
                e_hsv = 1; e_hs = 4'h1;
              end else if (!bus.ep_ready[ep]) begin
                e_hsv = 1; e_hs = 4'h5;
              end else begin
                m_ep = ep; m_wait = 0; e_xpid = bus.tok_pid;
                if (bus.tok_pid == 4'hE) m_mode = M_RX;
                else begin m_mode = M_TX; e_tx = data_pid_of(m_tog[ep]); end
              end
            end
          end
        end
        M_RX, M_TX: begin
          m_wait++;
          if (bus.xfer_done) begin
            if (m_mode == M_TX) begin
              if (bus.host_ack) nt[m_ep] = ~m_tog[m_ep];
              m_mode = M_IDLE;
            end else if (!bus.data_crc_ok) begin
              m_mode = M_IDLE;
            end else begin
              e_hsv = 1; e_hs = 4'hD;
              if (bus.data_pid == data_pid_of(m_tog[m_ep])) nt[m_ep] = ~m_tog[m_ep];
              else e_dup = 1;
              m_mode = M_ACK;
            end
          end else if (m_wait >= TMO) begin
            e_tmo = 1; m_mode = M_IDLE;
          end
        end
        M_ACK: m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
      m_tog = nt & ~bus.toggle_clr;
    end
  end

  always @(negedge phy_clk) begin
    if (m_live) begin
      chk("xfer_in",  {28'd0, bus.ep_xfer_in},  (m_mode == M_RX) ? (32'd1 << m_ep) : 32'd0);
      chk("xfer_out", {28'd0, bus.ep_xfer_out}, (m_mode == M_TX) ? (32'd1 << m_ep) : 32'd0);
      chk("xfer_pid", {28'd0, bus.ep_xfer_pid}, {28'd0, e_xpid});
      chk("tx_pid",   {28'd0, bus.tx_data_pid}, {28'd0, e_tx});
      chk("hs_valid", {31'd0, bus.hs_valid},    {31'd0, e_hsv});
      chk("hs_pid",   {28'd0, bus.hs_pid},      {28'd0, e_hs});
      chk("busy",     {31'd0, bus.busy},        {31'd0, m_mode != M_IDLE});
      chk("dup_drop", {31'd0, bus.dup_drop},    {31'd0, e_dup});
      chk("timeout",  {31'd0, bus.err_timeout}, {31'd0, e_tmo});
    end
  end

  task automatic tick();
    @(posedge phy_clk);
    #1;
  endtask

  task automatic tok(input logic [3:0] pid, input logic [3:0] ep);
    $display("token pid=%0h ep=%0d", pid, ep);
    bus.tok_valid = 1'b1; bus.tok_pid = pid; bus.tok_ep = ep;
    tick();
    bus.tok_valid = 1'b0;
  endtask

  task automatic done(input logic [3:0] dp, input logic crc, input logic ack);
    $display("xfer_done data_pid=%0h crc_ok=%0d host_ack=%0d", dp, crc, ack);
    bus.xfer_done = 1'b1; bus.data_pid = dp; bus.data_crc_ok = crc; bus.host_ack = ack;
    tick();
    bus.xfer_done = 1'b0;
  endtask

  initial begin
    bus.tok_valid = 0; bus.tok_pid = 0; bus.tok_ep = 0;
    bus.xfer_done = 0; bus.data_pid = 0; bus.data_crc_ok = 0; bus.host_ack = 0;
    bus.ep_ready = 4'b1101; bus.ep_stall = 4'b0000; bus.toggle_clr = 4'b0000;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_xfer_in", {28'd0, bus.ep_xfer_in}, 32'h0);
    chk("rst_tx_pid",  {28'd0, bus.tx_data_pid}, 32'hC);
    chk("rst_busy",    {31'd0, bus.busy}, 32'h0);

    // OUT EP2 DATA0 accepted, ACK one cycle after xfer_done
    tok(4'hE, 4'd2);
    chk("out2_xfer_in", {28'd0, bus.ep_xfer_in}, 32'h4);
    tick(); tick(); tick();
    chk("out2_hold", {28'd0, bus.ep_xfer_in}, 32'h4);
    done(4'hC, 1'b1, 1'b0);
    chk("out2_hsv", {31'd0, bus.hs_valid}, 32'h1);
    chk("out2_ack", {28'd0, bus.hs_pid}, 32'hD);
    chk("out2_drop", {28'd0, bus.ep_xfer_in}, 32'h0);
    tick();
    chk("out2_idle", {31'd0, bus.busy}, 32'h0);

    // Repeat with DATA0: duplicate, still ACKed
    tok(4'hE, 4'd2);
    done(4'hC, 1'b1, 1'b0);
    chk("dup_drop", {31'd0, bus.dup_drop}, 32'h1);
    chk("dup_ack", {28'd0, bus.hs_pid}, 32'hD);
    tick();

    // IN EP2 sends DATA1 since toggle[2]=1
    tok(4'h6, 4'd2);
    chk("in2_tx", {28'd0, bus.tx_data_pid}, 32'h4);
    chk("in2_out", {28'd0, bus.ep_xfer_out}, 32'h4);
    done(4'h0, 1'b1, 1'b1);
    chk("in2_nohs", {31'd0, bus.hs_valid}, 32'h0);

    // IN EP1 not ready -> NAK, then stalled -> STALL
    tok(4'h6, 4'd1);
    chk("nak_pid", {28'd0, bus.hs_pid}, 32'h5);
    chk("nak_out", {28'd0, bus.ep_xfer_out}, 32'h0);
    tick();
    chk("hs_hold", {28'd0, bus.hs_pid}, 32'h5);
    bus.ep_stall = 4'b0010;
    tok(4'h6, 4'd1);
    chk("stall_pid", {28'd0, bus.hs_pid}, 32'h1);
    bus.ep_stall = 4'b0000;
    tick();

    // IN EP3 timeout; a token arriving mid-wait is ignored
    tok(4'h6, 4'd3);
    chk("in3_out", {28'd0, bus.ep_xfer_out}, 32'h8);
    tok(4'hE, 4'd0);
    repeat (TMO - 2) tick();
    chk("in3_wait", {28'd0, bus.ep_xfer_out}, 32'h8);
    chk("in3_notmo", {31'd0, bus.err_timeout}, 32'h0);
    tick();
    chk("in3_tmo", {31'd0, bus.err_timeout}, 32'h1);
    chk("in3_drop", {28'd0, bus.ep_xfer_out}, 32'h0);
    tick();
    tok(4'h6, 4'd3);
    chk("in3_again_tx", {28'd0, bus.tx_data_pid}, 32'hC);
    done(4'h0, 1'b1, 1'b0);

    // Ignored: SOF, EP>3, SETUP to EP1, xfer_done in IDLE
    tok(4'hA, 4'd0);
    tok(4'hE, 4'd5);
    tok(4'h2, 4'd1);
    chk("ign_busy", {31'd0, bus.busy}, 32'h0);
    done(4'hC, 1'b1, 1'b1);
    chk("ign_done", {31'd0, bus.hs_valid}, 32'h0);

    // toggle_clr coincident with flip on EP0: clear wins
    tok(4'hE, 4'd0);
    bus.toggle_clr = 4'b0001;
    done(4'hC, 1'b1, 1'b0);
    bus.toggle_clr = 4'b0000;
    tick();
    tok(4'h6, 4'd0);
    chk("clr_wins_tx", {28'd0, bus.tx_data_pid}, 32'hC);
    done(4'h0, 1'b1, 1'b0);

    // Bad CRC on EP3 leaves toggle, so next DATA0 is not a duplicate
    tok(4'hE, 4'd3);
    done(4'hC, 1'b0, 1'b0);
    chk("crc_nohs", {31'd0, bus.hs_valid}, 32'h0);
    tok(4'hE, 4'd3);
    done(4'hC, 1'b1, 1'b0);
    chk("crc_nodup", {31'd0, bus.dup_drop}, 32'h0);
    tick();

    // Make toggle[0]=1, then SETUP EP0 while stalled forces DATA0
    tok(4'hE, 4'd0);
    done(4'hC, 1'b1, 1'b0);
    tick();
    bus.ep_stall = 4'b0001;
    tok(4'h2, 4'd0);
    chk("setup_in", {28'd0, bus.ep_xfer_in}, 32'h1);
    chk("setup_pid", {28'd0, bus.ep_xfer_pid}, 32'h2);
    done(4'hC, 1'b1, 1'b0);
    chk("setup_nodup", {31'd0, bus.dup_drop}, 32'h0);
    tick();

    // Reset in OUT_WAIT clears everything next cycle
    tok(4'h2, 4'd0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_in", {28'd0, bus.ep_xfer_in}, 32'h0);
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'h0);
    chk("rst_mid_pid", {28'd0, bus.ep_xfer_pid}, 32'h0);
    chk("rst_mid_tx", {28'd0, bus.tx_data_pid}, 32'hC);
    bus.ep_stall = 4'b0000;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
